// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus engine and its register sequencer:
// FSM state encodings, default phase timing and RTC register addresses.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_HOLD = 3'd2,
    GAP       = 3'd3,
    DATA      = 3'd4,
    DATA_HOLD = 3'd5,
    DONE      = 3'd6,
    REC       = 3'd7
  } rtc_state_t;

  // Default phase timing, in clk cycles
  localparam int RTC_CNT_W  = 8;
  localparam int RTC_T_ADDR = 10;
  localparam int RTC_T_AH   = 2;
  localparam int RTC_T_GAP  = 5;
  localparam int RTC_T_DATA = 12;
  localparam int RTC_T_DH   = 2;
  localparam int RTC_T_REC  = 2;

  // RTC register map shared with the sequencer
  localparam logic [7:0] RTC_ADDR_CMD    = 8'hF1;
  localparam logic [7:0] RTC_ADDR_SEC    = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN    = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR   = 8'h23;
  localparam logic [7:0] RTC_ADDR_DAY    = 8'h24;
  localparam logic [7:0] RTC_ADDR_MONTH  = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR   = 8'h26;
  localparam logic [7:0] RTC_ADDR_T_SEC  = 8'h31;
  localparam logic [7:0] RTC_ADDR_T_MIN  = 8'h32;
  localparam logic [7:0] RTC_ADDR_T_HOUR = 8'h33;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter for phase timing. Holds at zero; zero flag is a
// plain decode of the count.
module rtc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Physical bus engine for the multiplexed address/data RTC interface.
// Runs one address phase followed by one data phase per request and pulses
// fin on completion. Optional macro RTC_BUS_SYNC_EN adds a 2-flop
// synchronizer on rtc_bus_i and delays read capture by two cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for lectura/escritura
// ADDR      | address driven, wr_n strobe low (T_ADDR)
// ADDR_HOLD | strobe released, address still driven (T_AH)
// GAP       | chip deselected, bus released (T_GAP)
// DATA      | rd_n or wr_n strobe low (T_DATA)
// DATA_HOLD | strobes released, write data still driven (T_DH)
// DONE      | fin pulse, pins idle (1 cycle)
// REC       | recovery, requests ignored (T_REC)
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int CNT_W  = RTC_CNT_W,
  parameter int T_ADDR = RTC_T_ADDR,
  parameter int T_AH   = RTC_T_AH,
  parameter int T_GAP  = RTC_T_GAP,
  parameter int T_DATA = RTC_T_DATA,
  parameter int T_DH   = RTC_T_DH,
  parameter int T_REC  = RTC_T_REC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lectura,
  input  logic       escritura,
  input  logic [7:0] dirout,
  input  logic [7:0] dato,
  output logic       fin,
  output logic [7:0] dato_leido,
  output logic       busy,
  output logic       rtc_cs_n,
  output logic       rtc_ad,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [7:0] rtc_bus_o,
  output logic       rtc_bus_oe,
  input  logic [7:0] rtc_bus_i
);

  rtc_state_t       state, state_next;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;

  logic             op_wr;
  logic [7:0]       addr_q, data_q;
  logic             req, cap_evt;

  logic       fin_d, cs_n_d, ad_d, rd_n_d, wr_n_d, oe_d;
  logic [7:0] bus_o_d;

  assign req = lectura | escritura;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; each phase ends when its timer reaches zero
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (req)      state_next = ADDR;
      ADDR:      if (tmr_zero) state_next = ADDR_HOLD;
      ADDR_HOLD: if (tmr_zero) state_next = GAP;
      GAP:       if (tmr_zero) state_next = DATA;
      DATA:      if (tmr_zero) state_next = DATA_HOLD;
      DATA_HOLD: if (tmr_zero) state_next = DONE;
      DONE:                    state_next = REC;
      REC:       if (tmr_zero) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Timer reload on every phase change with the new phase length minus one
  always_comb begin
    tmr_load     = (state_next != state);
    tmr_load_val = '0;
    unique case (state_next)
      ADDR:      tmr_load_val = CNT_W'(T_ADDR - 1);
      ADDR_HOLD: tmr_load_val = CNT_W'(T_AH - 1);
      GAP:       tmr_load_val = CNT_W'(T_GAP - 1);
      DATA:      tmr_load_val = CNT_W'(T_DATA - 1);
      DATA_HOLD: tmr_load_val = CNT_W'(T_DH - 1);
      REC:       tmr_load_val = CNT_W'(T_REC - 1);
      default:   tmr_load_val = '0;
    endcase
  end

  // Pin values for the current state; registered below
  always_comb begin
    fin_d   = 1'b0;
    cs_n_d  = 1'b1;
    ad_d    = 1'b1;
    rd_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    oe_d    = 1'b0;
    bus_o_d = 8'h00;
    unique case (state)
      ADDR: begin
        cs_n_d  = 1'b0;
        wr_n_d  = 1'b0;
        oe_d    = 1'b1;
        bus_o_d = addr_q;
      end
      ADDR_HOLD: begin
        cs_n_d  = 1'b0;
        oe_d    = 1'b1;
        bus_o_d = addr_q;
      end
      DATA: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b0;
        if (op_wr) begin
          wr_n_d  = 1'b0;
          oe_d    = 1'b1;
          bus_o_d = data_q;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      DATA_HOLD: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b0;
        if (op_wr) begin
          oe_d    = 1'b1;
          bus_o_d = data_q;
        end
      end
      DONE:    fin_d = 1'b1;
      default: ;
    endcase
  end

  // Registered pins
  always_ff @(posedge clk) begin
    if (reset) begin
      fin        <= 1'b0;
      rtc_cs_n   <= 1'b1;
      rtc_ad     <= 1'b1;
      rtc_rd_n   <= 1'b1;
      rtc_wr_n   <= 1'b1;
      rtc_bus_oe <= 1'b0;
      rtc_bus_o  <= 8'h00;
    end else begin
      fin        <= fin_d;
      rtc_cs_n   <= cs_n_d;
      rtc_ad     <= ad_d;
      rtc_rd_n   <= rd_n_d;
      rtc_wr_n   <= wr_n_d;
      rtc_bus_oe <= oe_d;
      rtc_bus_o  <= bus_o_d;
    end
  end

  // Request latch at accept; write wins when both requests are high
  always_ff @(posedge clk) begin
    if (reset) begin
      op_wr  <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
    end else if (state == IDLE && req) begin
      op_wr  <= escritura;
      addr_q <= dirout;
      data_q <= dato;
    end
  end

  assign busy    = (state != IDLE);
  assign cap_evt = (state == DATA) && tmr_zero && !op_wr;

`ifdef RTC_BUS_SYNC_EN
  // Capture lands in DATA_HOLD, so it must last at least two cycles
  if (T_DH < 2) begin : g_bad_t_dh
    $error("rtc_bus_ctrl: T_DH must be >= 2 with RTC_BUS_SYNC_EN");
  end

  logic [7:0] bus_s1, bus_s2;
  logic       cap_p1, cap_p2;

  // Synchronize the bus and capture the value seen at the final DATA edge
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_s1     <= 8'h00;
      bus_s2     <= 8'h00;
      cap_p1     <= 1'b0;
      cap_p2     <= 1'b0;
      dato_leido <= 8'h00;
    end else begin
      bus_s1 <= rtc_bus_i;
      bus_s2 <= bus_s1;
      cap_p1 <= cap_evt;
      cap_p2 <= cap_p1;
      if (cap_p2)
        dato_leido <= bus_s2;
    end
  end
`else
  // Capture the bus directly at the final DATA edge of a read
  always_ff @(posedge clk) begin
    if (reset)
      dato_leido <= 8'h00;
    else if (cap_evt)
      dato_leido <= rtc_bus_i;
  end
`endif

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: directed scenarios followed by
// randomized requests, compared every cycle against a transaction-offset model.
module tb_rtc_bus_ctrl;

  logic       clk, reset, lectura, escritura;
  logic [7:0] dirout, dato, rtc_bus_i;
  logic       fin, busy, rtc_cs_n, rtc_ad, rtc_rd_n, rtc_wr_n, rtc_bus_oe;
  logic [7:0] dato_leido, rtc_bus_o;

  int checks = 0;
  int errors = 0;

  rtc_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .lectura    (lectura),
    .escritura  (escritura),
    .dirout     (dirout),
    .dato       (dato),
    .fin        (fin),
    .dato_leido (dato_leido),
    .busy       (busy),
    .rtc_cs_n   (rtc_cs_n),
    .rtc_ad     (rtc_ad),
    .rtc_rd_n   (rtc_rd_n),
    .rtc_wr_n   (rtc_wr_n),
    .rtc_bus_o  (rtc_bus_o),
    .rtc_bus_oe (rtc_bus_oe),
    .rtc_bus_i  (rtc_bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction timeline in cycles after the accepting edge:
  // ADDR 0-9, ADDR_HOLD 10-11, GAP 12-16, DATA 17-28, DATA_HOLD 29-30,
  // DONE 31, REC 32-33. Pins show the phase one edge later.
  localparam int N_CAP_EDGE = 29;
  localparam int N_IDLE     = 34;
`ifdef RTC_BUS_SYNC_EN
  localparam int N_CAP_VIS  = 31;
`else
  localparam int N_CAP_VIS  = 29;
`endif

  bit         m_active;
  int         m_n;
  bit         m_wr;
  logic [7:0] m_addr, m_data, m_dl, m_cap;

  // Reference model advance at each edge, then compare all outputs
  always @(posedge clk) begin
    int p;
    logic e_cs, e_ad, e_rd, e_wr, e_oe, e_fin;
    logic [7:0] e_bo;
    if (reset) begin
      m_active = 0;
      m_n      = 0;
      m_dl     = 8'h00;
    end else if (m_active) begin
      m_n++;
      if (!m_wr && m_n == N_CAP_EDGE) m_cap = rtc_bus_i;
      if (!m_wr && m_n == N_CAP_VIS)  m_dl  = m_cap;
      if (m_n == N_IDLE) m_active = 0;
    end else if (lectura || escritura) begin
      m_active = 1;
      m_n      = 0;
      m_wr     = escritura;
      m_addr   = dirout;
      m_data   = dato;
    end

    e_cs = 1; e_ad = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_fin = 0; e_bo = 8'h00;
    if (m_active && m_n >= 1) begin
      p = m_n - 1;
      if (p < 10) begin
        e_cs = 0; e_wr = 0; e_oe = 1; e_bo = m_addr;
      end else if (p < 12) begin
        e_cs = 0; e_oe = 1; e_bo = m_addr;
      end else if (p < 17) begin
        e_cs = 1;
      end else if (p < 29) begin
        e_cs = 0; e_ad = 0;
        if (m_wr) begin e_wr = 0; e_oe = 1; e_bo = m_data; end
        else e_rd = 0;
      end else if (p < 31) begin
        e_cs = 0; e_ad = 0;
        if (m_wr) begin e_oe = 1; e_bo = m_data; end
      end else if (p == 31) begin
        e_fin = 1;
      end
    end

    #1;
    check("cs_n",       32'(rtc_cs_n),   32'(e_cs));
    check("ad",         32'(rtc_ad),     32'(e_ad));
    check("rd_n",       32'(rtc_rd_n),   32'(e_rd));
    check("wr_n",       32'(rtc_wr_n),   32'(e_wr));
    check("bus_oe",     32'(rtc_bus_oe), 32'(e_oe));
    check("bus_o",      32'(rtc_bus_o),  32'(e_bo));
    check("fin",        32'(fin),        32'(e_fin));
    check("busy",       32'(busy),       32'(m_active));
    check("dato_leido", 32'(dato_leido), 32'(m_dl));
  end

  initial begin
    reset = 1; lectura = 0; escritura = 0;
    dirout = 8'h00; dato = 8'h00; rtc_bus_i = 8'h00;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Read of 0x21, request dropped after accept
    lectura = 1; dirout = 8'h21; rtc_bus_i = 8'h45;
    @(negedge clk);
    lectura = 0;
    repeat (40) @(negedge clk);
    check("read_byte", 32'(dato_leido), 32'h45);

    // Write 0x5A to 0x31; read byte must be untouched
    escritura = 1; dirout = 8'h31; dato = 8'h5A; rtc_bus_i = 8'h99;
    @(negedge clk);
    escritura = 0; dirout = 8'h00; dato = 8'h00;
    repeat (40) @(negedge clk);
    check("write_keeps_read", 32'(dato_leido), 32'h45);

    // Read request held across fin: back-to-back transactions
    lectura = 1; dirout = 8'h22; rtc_bus_i = 8'h3C;
    repeat (80) @(negedge clk);
    lectura = 0;
    repeat (45) @(negedge clk);

    // Both requests high: write wins
    lectura = 1; escritura = 1; dirout = 8'hF1; dato = 8'hA5;
    @(negedge clk);
    lectura = 0; escritura = 0;
    repeat (40) @(negedge clk);

    // Reset in the middle of a read (DATA phase)
    lectura = 1; dirout = 8'h23; rtc_bus_i = 8'h77;
    @(negedge clk);
    lectura = 0;
    repeat (19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_cs_n", 32'(rtc_cs_n), 32'h1);
    repeat (40) @(negedge clk);
    check("reset_read_byte", 32'(dato_leido), 32'h00);

    // Randomized traffic with per-cycle bus noise and occasional reset
    repeat (4000) begin
      rtc_bus_i = 8'($urandom);
      dirout    = 8'($urandom);
      dato      = 8'($urandom);
      lectura   = ($urandom_range(0, 15) == 0);
      escritura = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 0; lectura = 0; escritura = 0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
